fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries; a power of two, at least 2.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, fetch address after reset.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_i  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port start_i  input  1  fetch enable; when low, no new fetches (dequeue continues).
REQ-006 SHALL have port imem_addr_o  output  32  address to the asynchronous-read instruction memory.
REQ-007 SHALL have port imem_inst_i  input  32  instruction returned for imem_addr_o in the same cycle.
REQ-008 SHALL have port redirect_i  input  1  branch/jump taken; flush and refetch.
REQ-009 SHALL have port redirect_pc_i  input  32  redirect target.
REQ-010 SHALL have port deq_valid_o  output  1  head entry available to IF/ID.
REQ-011 SHALL have port deq_ready_i  input  1  IF/ID accepts the entry (not stalled).
REQ-012 SHALL have port pc_o  output  32  PC of head entry.
REQ-013 SHALL have port inst_o  output  32  instruction of head entry.
REQ-014 SHALL have port count_o  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-015 SHALL hold fetch_pc register; imem_addr_o = fetch_pc combinationally.
REQ-016 SHALL define deq_fire = deq_valid_o & deq_ready_i.
REQ-017 SHALL define fetch_fire = start_i & ~redirect_i & (count_o < DEPTH | deq_fire).
REQ-018 On fetch_fire: push {fetch_pc, imem_inst_i} at tail; fetch_pc <= fetch_pc + 4, wrapping modulo 2^32.
REQ-019 On deq_fire: advance head; entries leave in strict push order.
REQ-020 Push and pop in the same cycle SHALL leave count_o unchanged, including when full.
REQ-021 When full, with no dequeue: no fetch; fetch_pc and contents hold.
REQ-022 deq_valid_o = (count_o != 0) & ~redirect_i.
REQ-023 When the queue is empty and no bypass occurs: pc_o and inst_o SHALL be 0.
REQ-024 Redirect has highest priority: next cycle count_o = 0, fetch_pc = {redirect_pc_i[31:2], 2'b00}, no push; any dequeue that cycle is void.
REQ-025 Head and tail pointers SHALL wrap modulo DEPTH; count_o SHALL never exceed DEPTH.
REQ-026 Latency: an instruction fetched in cycle N SHALL be first visible on deq outputs in cycle N+1 (bypass per REQ-030).

Reset
REQ-027 rst_i high at a clock edge SHALL set: fetch_pc = RESET_PC; count_o = 0; pointers = 0; deq_valid_o = 0; pc_o = 0; inst_o = 0.
REQ-028 rst_i SHALL override redirect_i, start_i and in-flight push/pop in the same cycle.

Configuration
REQ-029 Macro FETCH_QUEUE_BYPASS_EN selects the empty-queue bypass.
REQ-030 With the macro defined: when count_o = 0, start_i = 1 and redirect_i = 0, deq_valid_o = 1, pc_o = fetch_pc and inst_o = imem_inst_i in the same cycle.
- If deq_ready_i = 1, the entry is consumed without being written.
- Otherwise it is pushed as normal.
REQ-031 Without the macro: no bypass; minimum latency is one cycle per REQ-026.

Verification
REQ-032 Reset, then start_i = 1, deq_ready_i = 1 -> deq pc_o sequence 0x0, 0x4, 0x8, one per cycle (bypass: first valid in the cycle after reset; else one cycle later).
REQ-033 deq_ready_i = 0 for 6 cycles, DEPTH = 4 -> count_o saturates at 4; imem_addr_o holds 0x10; contents 0x0–0xC preserved.
REQ-034 Full queue, deq_ready_i = 1, start_i = 1 -> count_o stays 4; pc_o advances by 4 per cycle.
REQ-035 redirect_i = 1 with redirect_pc_i = 0x0000_0103 while 3 entries are queued -> deq_valid_o = 0 that cycle; next cycle count_o = 0 and imem_addr_o = 0x100.
REQ-036 fetch_pc = 0xFFFF_FFFC, fetch fires -> next imem_addr_o = 0x0000_0000.
REQ-037 rst_i asserted in the same cycle as redirect_i and push -> next cycle count_o = 0, imem_addr_o = RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue: fetches sequential PCs from an async-read imem into a small FIFO.
// Define FETCH_QUEUE_BYPASS_EN to let an empty queue hand the current fetch straight to IF/ID.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    output logic [31:0]              imem_addr_o,
    input  logic [31:0]              imem_inst_i,
    input  logic                     redirect_i,
    input  logic [31:0]              redirect_pc_i,
    output logic                     deq_valid_o,
    input  logic                     deq_ready_i,
    output logic [31:0]              pc_o,
    output logic [31:0]              inst_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];

    logic empty;
    logic bypass;
    logic deq_fire;
    logic fetch_fire;
    logic push;
    logic pop;
    logic [1:0] unused_redirect_bits;

    assign imem_addr_o          = fetch_pc;
    assign count_o              = count;
    assign unused_redirect_bits = redirect_pc_i[1:0];

    always_comb begin
        empty = (count == '0);
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass = empty & start_i & ~redirect_i;
`else
        bypass = 1'b0;
`endif
        deq_valid_o = (~empty & ~redirect_i) | bypass;
        deq_fire    = deq_valid_o & deq_ready_i;
        fetch_fire  = start_i & ~redirect_i & ((count < FULL_COUNT) | deq_fire);
        // A bypassed fetch that is accepted immediately never occupies a slot.
        push        = fetch_fire & ~(bypass & deq_ready_i);
        pop         = deq_fire & ~empty;
    end

    always_comb begin
        pc_o   = 32'h0;
        inst_o = 32'h0;
        if (!empty) begin
            pc_o   = pc_mem[head];
            inst_o = inst_mem[head];
        end else if (bypass) begin
            pc_o   = fetch_pc;
            inst_o = imem_inst_i;
        end
    end

    // Reset beats redirect, which beats any push/pop in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc <= RESET_PC;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else if (redirect_i) begin
            fetch_pc <= {redirect_pc_i[31:2], 2'b00};
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (fetch_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            pc_mem[tail]   <= fetch_pc;
            inst_mem[tail] <= imem_inst_i;
        end
    end

endmodule
